// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner encoding, read-tag type and starve counter width shared by the arbiter files
package mem_arb_pkg;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// arb_tag_pipe: DEPTH-stage shift register of {valid, owner} read tags with synchronous clear
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t stage [DEPTH];
  always_ff @(posedge clk) begin
    stage[0] <= rst ? '0 : tag_in;
    for (int i = 1; i < DEPTH; i++) stage[i] <= rst ? '0 : stage[i-1];
  end
  assign tag_out = stage[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IF/DM arbiter for one single-port memory, DM priority with IF starvation guard; ARB_STATS_EN adds stall counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 13,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_if_stall,
  output logic [15:0]   stat_dm_stall
`endif
);
  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  logic [DW-1:0]       if_hold, dm_hold;
  tag_t                push, head;
  arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (push),
    .tag_out(head)
  );
  always_comb begin
    starved     = starve_cnt == STARVE_W'(STARVE_MAX);
    if_gnt      = !rst && if_req && (!dm_req || starved);
    dm_gnt      = !rst && dm_req && !if_gnt;
    mem_en      = if_gnt || dm_gnt;
    mem_we      = dm_gnt && dm_we;
    mem_addr    = if_gnt ? if_addr : dm_gnt ? dm_addr : '0;
    mem_wdata   = mem_we ? dm_wdata : '0;
    stall       = !rst && ((if_req && !if_gnt) || (dm_req && !dm_gnt));
    push.valid  = mem_en && !mem_we;
    push.owner  = dm_gnt ? OWN_DM : OWN_IF;
    if_rvalid   = !rst && head.valid && head.owner == OWN_IF;
    dm_rvalid   = !rst && head.valid && head.owner == OWN_DM;
    if_rdata    = if_rvalid ? mem_rdata : rst ? '0 : if_hold;
    dm_rdata    = dm_rvalid ? mem_rdata : rst ? '0 : dm_hold;
  end
  always_ff @(posedge clk) begin
    if_hold    <= rst ? '0 : if_rvalid ? mem_rdata : if_hold;
    dm_hold    <= rst ? '0 : dm_rvalid ? mem_rdata : dm_hold;
    starve_cnt <= (rst || !if_req || if_gnt) ? '0 : starved ? starve_cnt : starve_cnt + STARVE_W'(1);
  end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    stat_if_stall <= rst ? '0 : stat_if_stall + 16'(if_req && !if_gnt && stat_if_stall != '1);
    stat_dm_stall <= rst ? '0 : stat_dm_stall + 16'(dm_req && !dm_gnt && stat_dm_stall != '1);
  end
`endif
endmodule
